map_background_store: RTL and testbench
=======================================

MAP_BACKGROUND_STORE -- requirements
Module: map_background_store

Interface
REQ-001 The parameter H_PIXELS SHALL default to 160 and set the number of pixel columns.
REQ-002 The parameter V_PIXELS SHALL default to 120 and set the number of pixel rows.
REQ-003 The parameter COLOUR_W SHALL default to 9 and set the colour word width (3 bits per R/G/B).
REQ-004 The parameter INIT_FILE SHALL default to "map_background.mif" and name the background image that preloads the array.
REQ-005 The port list SHALL be:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- x  in  8  pixel column, 0..159.
- y  in  7  pixel row, 0..119.
- data  in  9  write colour.
- wren  in  1  write enable.
- mem_address  out  15  combinational linear address.
- q  out  9  registered read colour.
- addr_valid  out  1  combinational: x<160 and y<120.

Function
REQ-006 mem_address SHALL equal y*160 + x, computed as (y<<7)+(y<<5)+x in 15 bits with no truncation (max 19199).
REQ-007 When addr_valid=0, mem_address SHALL still equal the formula value truncated to 15 bits.
REQ-008 Storage SHALL be 19200 words of 9 bits, indexed by mem_address.
REQ-009 Storage SHALL be preloaded from INIT_FILE at configuration, row-major with index 0 = (0,0).
REQ-010 On each rising clk with resetn=1, q SHALL load the word at mem_address sampled on that edge, giving exactly 1 cycle read latency.
REQ-011 When addr_valid=0 on a clock edge, q SHALL load 0.
REQ-012 On a rising clk with wren=1 and addr_valid=1, data SHALL be written to mem_address.
REQ-013 When wren=1 and addr_valid=0, the write SHALL be ignored.
REQ-014 On a same-edge read and write to one address, q SHALL return the old data (read-before-write).
REQ-015 Back-to-back reads SHALL be sustained every cycle with no stall or handshake.
REQ-016 A consumer scanning a 20x20 tile at origin (X0,Y0) SHALL obtain each colour one cycle after presenting (X0+i, Y0+j); the block adds no further delay.

Reset
REQ-017 resetn=0 SHALL asynchronously force q to 0.
REQ-018 While resetn=0, writes SHALL be ignored.
REQ-019 Reset SHALL NOT clear or reload the storage array.
REQ-020 After resetn deasserts, the first clock edge SHALL produce valid read data per REQ-010.
REQ-021 A reset asserted during a read SHALL discard that read; q stays 0 until the first post-reset edge.

Structure
REQ-022 H_PIXELS, V_PIXELS, COLOUR_W, address width 15 and depth 19200 SHALL live in the shared VGA package used by all 160x120 blocks.
REQ-023 The coordinate-to-address logic (REQ-006/007 plus addr_valid) SHALL be one combinational sub-module, memory_address_translator_160x120, reused by other 160x120 drawers.
REQ-024 The storage SHALL be inferable as a single-port synchronous block RAM, with the q reset and the out-of-range zeroing on the output register only.

Verification
REQ-025 x=0,y=0 -> mem_address=0; x=159,y=119 -> mem_address=19199; x=5,y=2 -> mem_address=325, addr_valid=1.
REQ-026 Write data=9'h1A5 at (10,3), then read (10,3) -> q=9'h1A5 exactly one cycle after the read address is presented; neighbour (11,3) keeps its preload value.
REQ-027 x=160,y=0 with wren=1,data=9'h1FF -> addr_valid=0, q=0 next cycle; address 160 (=(0,1)) is unchanged.
REQ-028 Simultaneous write 9'h0F0 and read at (7,7) holding old 9'h000 -> q=9'h000 that cycle, then q=9'h0F0 on the next cycle.
REQ-029 Continuous 20x20 scan from (40,30) -> 400 consecutive q values match preload words 40+30*160 ... 59+49*160, each lagging its address by 1 cycle.
REQ-030 Assert resetn=0 mid-scan -> q=0 immediately (asynchronous); preload/written contents intact on resume.

Source files
------------

// File: rtl/map_background_store_pkg.sv
// Shared 160x120 VGA frame-buffer geometry used by every 160x120 drawing block.
package map_background_store_pkg;

    localparam int unsigned VGA_H_PIXELS = 160;
    localparam int unsigned VGA_V_PIXELS = 120;
    localparam int unsigned VGA_COLOUR_W = 9;
    localparam int unsigned VGA_X_W      = 8;
    localparam int unsigned VGA_Y_W      = 7;
    localparam int unsigned VGA_ADDR_W   = 15;
    localparam int unsigned VGA_DEPTH    = VGA_H_PIXELS * VGA_V_PIXELS;

    // Row-major linear address y*160 + x, built from shifts so no multiplier is needed.
    function automatic logic [VGA_ADDR_W-1:0] pixel_address(
        input logic [VGA_X_W-1:0] px,
        input logic [VGA_Y_W-1:0] py
    );
        return (VGA_ADDR_W'(py) << 7) + (VGA_ADDR_W'(py) << 5) + VGA_ADDR_W'(px);
    endfunction

endpackage

// File: rtl/memory_address_translator_160x120.sv
// Combinational (x, y) -> linear frame-buffer address plus in-range flag.
module memory_address_translator_160x120
    import map_background_store_pkg::*;
#(
    parameter int unsigned H_PIXELS = VGA_H_PIXELS,
    parameter int unsigned V_PIXELS = VGA_V_PIXELS
) (
    input  logic [VGA_X_W-1:0]    x,
    input  logic [VGA_Y_W-1:0]    y,
    output logic [VGA_ADDR_W-1:0] mem_address,
    output logic                  addr_valid
);

    // Address is always the raw formula; range checking is reported separately.
    always_comb begin
        mem_address = pixel_address(x, y);
        addr_valid  = (x < VGA_X_W'(H_PIXELS)) && (y < VGA_Y_W'(V_PIXELS));
    end

endmodule

// File: rtl/map_background_store.sv
// 160x120 background image store: single-port RAM with a registered, zero-on-invalid read port.
module map_background_store
    import map_background_store_pkg::*;
#(
    parameter int unsigned H_PIXELS  = VGA_H_PIXELS,
    parameter int unsigned V_PIXELS  = VGA_V_PIXELS,
    parameter int unsigned COLOUR_W  = VGA_COLOUR_W,
    parameter string       INIT_FILE = "map_background.mif"
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [VGA_X_W-1:0]    x,
    input  logic [VGA_Y_W-1:0]    y,
    input  logic [COLOUR_W-1:0]   data,
    input  logic                  wren,
    output logic [VGA_ADDR_W-1:0] mem_address,
    output logic [COLOUR_W-1:0]   q,
    output logic                  addr_valid
);

    // Background image is loaded into the RAM at configuration via the init attribute.
    (* ram_init_file = INIT_FILE *)
    logic [COLOUR_W-1:0] mem [VGA_DEPTH];

    // Image name only matters to the RAM init flow; keep it part of the elaborated design.
    logic unused_init_file;
    assign unused_init_file = (INIT_FILE == "");

    memory_address_translator_160x120 #(
        .H_PIXELS (H_PIXELS),
        .V_PIXELS (V_PIXELS)
    ) u_translator (
        .x           (x),
        .y           (y),
        .mem_address (mem_address),
        .addr_valid  (addr_valid)
    );

    // Write port: in-range writes only, and never while reset is held; array is never cleared.
    always_ff @(posedge clk) begin
        if (resetn && wren && addr_valid) begin
            mem[mem_address] <= data;
        end
    end

    // Read register: old data on a same-address write, zero for out-of-range, async clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (addr_valid) begin
            q <= mem[mem_address];
        end else begin
            q <= '0;
        end
    end

endmodule

// File: tb/tb_map_background_store.sv
// Directed self-checking bench for map_background_store.
module tb_map_background_store;
    import map_background_store_pkg::*;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  x      = '0;
    logic [6:0]  y      = '0;
    logic [8:0]  data   = '0;
    logic        wren   = 1'b0;
    logic [14:0] mem_address;
    logic [8:0]  q;
    logic        addr_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] model [19200];

    always #5 clk = ~clk;

    map_background_store dut (
        .clk         (clk),
        .resetn      (resetn),
        .x           (x),
        .y           (y),
        .data        (data),
        .wren        (wren),
        .mem_address (mem_address),
        .q           (q),
        .addr_valid  (addr_valid)
    );

    function automatic logic [8:0] pre_word(input int i);
        return 9'((i * 37) ^ (i >> 3));
    endfunction

    task automatic test_reset;
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (q !== 9'h000) begin n_err++; $display("FAIL reset_q: got %h expected 000", q); end
        x = 8'd3; y = 7'd3; wren = 1'b1; data = 9'h1FF;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 9'h000) begin n_err++; $display("FAIL reset_hold_q: got %h expected 000", q); end
        wren = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== model[483]) begin n_err++; $display("FAIL first_read_after_reset: got %h expected %h", q, model[483]); end
    endtask

    task automatic test_address;
        int          tx [6] = '{0, 159, 5, 160, 0, 255};
        int          ty [6] = '{0, 119, 2, 0, 120, 127};
        logic [14:0] ea [6] = '{15'd0, 15'd19199, 15'd325, 15'd160, 15'd19200, 15'd20575};
        logic        ev [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            x = 8'(tx[k]); y = 7'(ty[k]);
            #1;
            n_cmp++;
            if (mem_address !== ea[k]) begin
                n_err++; $display("FAIL addr_%0d: got %0d expected %0d", k, mem_address, ea[k]);
            end
            n_cmp++;
            if (addr_valid !== ev[k]) begin
                n_err++; $display("FAIL valid_%0d: got %b expected %b", k, addr_valid, ev[k]);
            end
        end
    endtask

    task automatic test_preload_read;
        int tx [3] = '{0, 159, 3};
        int ty [3] = '{0, 119, 50};
        int idx;
        for (int k = 0; k < 3; k++) begin
            x = 8'(tx[k]); y = 7'(ty[k]);
            idx = ty[k] * 160 + tx[k];
            @(posedge clk); #1;
            n_cmp++;
            if (q !== model[idx]) begin
                n_err++; $display("FAIL preload_%0d: got %h expected %h", k, q, model[idx]);
            end
        end
    endtask

    task automatic test_write_read;
        x = 8'd10; y = 7'd3; data = 9'h1A5; wren = 1'b1;
        @(posedge clk); #1;
        wren = 1'b0;
        n_cmp++;
        if (q !== model[490]) begin n_err++; $display("FAIL write_edge_old: got %h expected %h", q, model[490]); end
        model[490] = 9'h1A5;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 9'h1A5) begin n_err++; $display("FAIL write_readback: got %h expected 1a5", q); end
        x = 8'd11;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== model[491]) begin n_err++; $display("FAIL neighbour: got %h expected %h", q, model[491]); end
    endtask

    task automatic test_out_of_range;
        x = 8'd160; y = 7'd0; data = 9'h1FF; wren = 1'b1;
        #1;
        n_cmp++;
        if (addr_valid !== 1'b0) begin n_err++; $display("FAIL oor_valid: got %b expected 0", addr_valid); end
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 9'h000) begin n_err++; $display("FAIL oor_q: got %h expected 000", q); end
        wren = 1'b0; x = 8'd0; y = 7'd1;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== model[160]) begin n_err++; $display("FAIL oor_write_ignored: got %h expected %h", q, model[160]); end
        x = 8'd0; y = 7'd120;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 9'h000) begin n_err++; $display("FAIL oor_row_q: got %h expected 000", q); end
    endtask

    task automatic test_read_before_write;
        x = 8'd7; y = 7'd7; data = 9'h000; wren = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== model[1127]) begin n_err++; $display("FAIL rbw_clear_old: got %h expected %h", q, model[1127]); end
        model[1127] = 9'h000;
        data = 9'h0F0;
        @(posedge clk); #1;
        wren = 1'b0;
        n_cmp++;
        if (q !== 9'h000) begin n_err++; $display("FAIL rbw_same_edge: got %h expected 000", q); end
        model[1127] = 9'h0F0;
        @(posedge clk); #1;
        n_cmp++;
        if (q !== 9'h0F0) begin n_err++; $display("FAIL rbw_next: got %h expected 0f0", q); end
    endtask

    task automatic test_back_to_back_scan;
        int prev = -1;
        int idx;
        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < 20; i++) begin
                x = 8'(40 + i); y = 7'(30 + j);
                idx = (30 + j) * 160 + 40 + i;
                #1;
                if (prev >= 0) begin
                    n_cmp++;
                    if (q !== model[prev]) begin
                        n_err++; $display("FAIL scan_hold (%0d,%0d): got %h expected %h", 40 + i, 30 + j, q, model[prev]);
                    end
                end
                @(posedge clk); #1;
                n_cmp++;
                if (q !== model[idx]) begin
                    n_err++; $display("FAIL scan_q (%0d,%0d): got %h expected %h", 40 + i, 30 + j, q, model[idx]);
                end
                prev = idx;
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        int rx [4] = '{10, 7, 40, 0};
        int ry [4] = '{3, 7, 30, 1};
        int idx;
        for (int i = 0; i < 5; i++) begin
            x = 8'(40 + i); y = 7'd30;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (q !== model[4844]) begin n_err++; $display("FAIL pre_reset_scan: got %h expected %h", q, model[4844]); end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (q !== 9'h000) begin n_err++; $display("FAIL async_reset_q: got %h expected 000", q); end
        x = 8'd41; y = 7'd30; data = 9'h1FF; wren = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b1; wren = 1'b0;
        #1;
        n_cmp++;
        if (q !== 9'h000) begin n_err++; $display("FAIL post_reset_hold: got %h expected 000", q); end
        @(posedge clk); #1;
        n_cmp++;
        if (q !== model[4841]) begin n_err++; $display("FAIL reset_write_ignored: got %h expected %h", q, model[4841]); end
        for (int k = 0; k < 4; k++) begin
            x = 8'(rx[k]); y = 7'(ry[k]);
            idx = ry[k] * 160 + rx[k];
            @(posedge clk); #1;
            n_cmp++;
            if (q !== model[idx]) begin
                n_err++; $display("FAIL contents_intact_%0d: got %h expected %h", k, q, model[idx]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) begin
            model[i]   = pre_word(i);
            dut.mem[i] = pre_word(i);
        end
        test_reset();
        test_address();
        test_preload_read();
        test_write_read();
        test_out_of_range();
        test_read_before_write();
        test_back_to_back_scan();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
